// File: rtl/dac_pcm_fifo.sv
// -----------------------------------------------------------------------------
// dac_pcm_fifo
//
// Stereo PCM sample FIFO between a local-bus register interface and a codec
// driver. Software stages a left sample, then writing the right sample pushes
// the {L, R} pair as one entry. The codec driver pulses dac_pcm_nxt to advance
// to the next pair, which appears on the registered DAC outputs one clk later.
//
// Register map (lb_addr):
//   0x00 CTRL      bit0 enable (R/W), bit1 flush (write-1 pulse, reads 0)
//   0x01 STATUS    [15:0] occupancy, 16 empty, 17 full, 18 underflow sticky,
//                  19 overflow sticky (write 1 to bit18/bit19 to clear)
//   0x02 LPCM_WR   left-sample staging register
//   0x03 RPCM_WR   pushes {staged L, written R}
//   0x04 LOW_THR   [PTR_W:0] low-water threshold
//   0x05 UFLOW_CNT [15:0] saturating underflow count, any write clears
//   other          reads return 0xdeadbabe
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   lb_wr_en / lb_rd_en        local-bus write / read strobes
//   lb_addr, lb_wr_data        register address and write data
//   lb_wr_valid, lb_rd_valid   one-cycle acknowledges, one clk after strobe
//   lb_rd_data                 registered read data, held between reads
//   dac_pcm_nxt                codec request for the next sample pair
//   dac_lpcm_data/rpcm_data    current left/right sample, registered
//   buff_low                   enable AND (occupancy < LOW_THR), registered
//
// Build option:
//   DAC_PCM_FIFO_UFLOW_REPEAT_EN  defined: outputs hold the last pair on
//                                 underflow; undefined: outputs go to 0.
// -----------------------------------------------------------------------------
module dac_pcm_fifo #(
    parameter int LB_DATA_W  = 32,
    parameter int LB_ADDR_W  = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lb_wr_en,
    input  logic                 lb_rd_en,
    input  logic [LB_ADDR_W-1:0] lb_addr,
    input  logic [LB_DATA_W-1:0] lb_wr_data,
    output logic                 lb_wr_valid,
    output logic                 lb_rd_valid,
    output logic [LB_DATA_W-1:0] lb_rd_data,
    input  logic                 dac_pcm_nxt,
    output logic [31:0]          dac_lpcm_data,
    output logic [31:0]          dac_rpcm_data,
    output logic                 buff_low
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [LB_ADDR_W-1:0] A_CTRL   = LB_ADDR_W'(8'h00);
    localparam logic [LB_ADDR_W-1:0] A_STATUS = LB_ADDR_W'(8'h01);
    localparam logic [LB_ADDR_W-1:0] A_LPCM   = LB_ADDR_W'(8'h02);
    localparam logic [LB_ADDR_W-1:0] A_RPCM   = LB_ADDR_W'(8'h03);
    localparam logic [LB_ADDR_W-1:0] A_THR    = LB_ADDR_W'(8'h04);
    localparam logic [LB_ADDR_W-1:0] A_UCNT   = LB_ADDR_W'(8'h05);

    // ---------------------------------------------------------------- state
    logic                 enable_q, enable_d;
    logic                 uflow_sticky_q, uflow_sticky_d;
    logic                 oflow_sticky_q, oflow_sticky_d;
    logic [15:0]          uflow_cnt_q, uflow_cnt_d;
    logic [31:0]          stage_l_q, stage_l_d;
    logic [PTR_W:0]       low_thr_q, low_thr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       occ_q, occ_d;
    logic [31:0]          dac_l_q, dac_l_d;
    logic [31:0]          dac_r_q, dac_r_d;
    logic                 buff_low_q, buff_low_d;
    logic                 lb_wr_valid_q;
    logic                 lb_rd_valid_q;
    logic [LB_DATA_W-1:0] lb_rd_data_q, lb_rd_data_d;

    logic [63:0]          mem [FIFO_DEPTH];

    // ---------------------------------------------------------- decode
    logic        wr_data_word;
    logic [31:0] wr_word;
    logic        flush, push_req, pop_req;
    logic        empty, full;
    logic        pop_ok, push_ok, underflow, overflow;
    logic [63:0] head;
    logic [31:0] rd_word;

    assign wr_word      = lb_wr_data[31:0];
    assign wr_data_word = lb_wr_en;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == FULL_OCC);

    // Flush wins over any same-cycle push or pop.
    assign flush    = wr_data_word && (lb_addr == A_CTRL) && wr_word[1];
    assign push_req = wr_data_word && (lb_addr == A_RPCM) && !flush;
    assign pop_req  = dac_pcm_nxt && enable_q && !flush;

    // Pop sees pre-push state; a push into a full FIFO still lands when the
    // same cycle frees a slot.
    assign pop_ok    = pop_req && !empty;
    assign underflow = pop_req && empty;
    assign push_ok   = push_req && (!full || pop_ok);
    assign overflow  = push_req && full && !pop_ok;

    assign head = mem[rd_ptr_q];

    always_comb begin
        rd_word = 32'hdeadbabe;
        case (lb_addr)
            A_CTRL:   rd_word = {31'd0, enable_q};
            A_STATUS: rd_word = {12'd0, oflow_sticky_q, uflow_sticky_q,
                                 full, empty, 16'(occ_q)};
            A_LPCM:   rd_word = stage_l_q;
            A_RPCM:   rd_word = 32'd0;
            A_THR:    rd_word = 32'(low_thr_q);
            A_UCNT:   rd_word = {16'd0, uflow_cnt_q};
            default:  rd_word = 32'hdeadbabe;
        endcase
    end

    // ------------------------------------------------------ next state
    // NOTE: every _d gets its hold value first so no path through this block
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        enable_d       = enable_q;
        uflow_sticky_d = uflow_sticky_q;
        oflow_sticky_d = oflow_sticky_q;
        uflow_cnt_d    = uflow_cnt_q;
        stage_l_d      = stage_l_q;
        low_thr_d      = low_thr_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q;
        dac_l_d        = dac_l_q;
        dac_r_d        = dac_r_q;

        if (wr_data_word) begin
            case (lb_addr)
                A_CTRL:   enable_d = wr_word[0];
                A_STATUS: begin
                    if (wr_word[18]) uflow_sticky_d = 1'b0;
                    if (wr_word[19]) oflow_sticky_d = 1'b0;
                end
                A_LPCM:   stage_l_d   = wr_word;
                A_THR:    low_thr_d   = wr_word[PTR_W:0];
                A_UCNT:   uflow_cnt_d = 16'd0;
                default:  ;
            endcase
        end

        // Hardware events override a same-cycle software clear.
        if (underflow) begin
            uflow_sticky_d = 1'b1;
            if (uflow_cnt_d != 16'hffff) uflow_cnt_d = uflow_cnt_d + 16'd1;
        end
        if (overflow) oflow_sticky_d = 1'b1;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
                2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
                default: occ_d = occ_q;
            endcase
        end

        // Outputs follow enable_d so they read 0 exactly while enable reads 0.
        if (!enable_d || flush) begin
            dac_l_d = 32'd0;
            dac_r_d = 32'd0;
        end else if (pop_ok) begin
            dac_l_d = head[63:32];
            dac_r_d = head[31:0];
        end
`ifdef DAC_PCM_FIFO_UFLOW_REPEAT_EN
        // Underflow leaves the previous pair on the outputs.
`else
        else if (underflow) begin
            dac_l_d = 32'd0;
            dac_r_d = 32'd0;
        end
`endif
    end

    // Compares the already-registered occupancy, so the flag trails each
    // occupancy change by one clk.
    assign buff_low_d   = enable_q && (occ_q < low_thr_q);
    assign lb_rd_data_d = lb_rd_en ? LB_DATA_W'(rd_word) : lb_rd_data_q;

    // ------------------------------------------------------------ flops
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q       <= 1'b0;
            uflow_sticky_q <= 1'b0;
            oflow_sticky_q <= 1'b0;
            uflow_cnt_q    <= 16'd0;
            stage_l_q      <= 32'd0;
            low_thr_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            dac_l_q        <= 32'd0;
            dac_r_q        <= 32'd0;
            buff_low_q     <= 1'b0;
            lb_wr_valid_q  <= 1'b0;
            lb_rd_valid_q  <= 1'b0;
            lb_rd_data_q   <= '0;
        end else begin
            enable_q       <= enable_d;
            uflow_sticky_q <= uflow_sticky_d;
            oflow_sticky_q <= oflow_sticky_d;
            uflow_cnt_q    <= uflow_cnt_d;
            stage_l_q      <= stage_l_d;
            low_thr_q      <= low_thr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            dac_l_q        <= dac_l_d;
            dac_r_q        <= dac_r_d;
            buff_low_q     <= buff_low_d;
            lb_wr_valid_q  <= lb_wr_en;
            lb_rd_valid_q  <= lb_rd_en;
            lb_rd_data_q   <= lb_rd_data_d;
        end
    end

    // NOTE: the sample array has no reset; occupancy and pointers define
    // which entries are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {stage_l_q, wr_word};
    end

    assign lb_wr_valid   = lb_wr_valid_q;
    assign lb_rd_valid   = lb_rd_valid_q;
    assign lb_rd_data    = lb_rd_data_q;
    assign dac_lpcm_data = dac_l_q;
    assign dac_rpcm_data = dac_r_q;
    assign buff_low      = buff_low_q;

endmodule

// File: tb/tb_dac_pcm_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for dac_pcm_fifo. Stimulus tasks update a queue-based reference
// model and push expected responses into scoreboards; a monitor on the falling
// edge pops and compares whenever the DUT presents read data, a new sample
// pair, or a completed cycle (buff_low / lb_wr_valid).
// -----------------------------------------------------------------------------
module tb_dac_pcm_fifo;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lb_wr_en = 1'b0;
    logic        lb_rd_en = 1'b0;
    logic [7:0]  lb_addr = 8'd0;
    logic [31:0] lb_wr_data = 32'd0;
    logic        lb_wr_valid;
    logic        lb_rd_valid;
    logic [31:0] lb_rd_data;
    logic        dac_pcm_nxt = 1'b0;
    logic [31:0] dac_lpcm_data;
    logic [31:0] dac_rpcm_data;
    logic        buff_low;

    always #5 clk = ~clk;

    dac_pcm_fifo #(.LB_DATA_W(32), .LB_ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lb_wr_en     (lb_wr_en),
        .lb_rd_en     (lb_rd_en),
        .lb_addr      (lb_addr),
        .lb_wr_data   (lb_wr_data),
        .lb_wr_valid  (lb_wr_valid),
        .lb_rd_valid  (lb_rd_valid),
        .lb_rd_data   (lb_rd_data),
        .dac_pcm_nxt  (dac_pcm_nxt),
        .dac_lpcm_data(dac_lpcm_data),
        .dac_rpcm_data(dac_rpcm_data),
        .buff_low     (buff_low)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic missing(string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected_output required=no_output", name);
    endtask

    // ------------------------------------------------------ reference model
    logic [63:0] mq [$];
    bit          m_en, m_uf, m_of;
    int          m_cnt, m_thr;
    logic [31:0] m_stage;
    logic [63:0] m_out;

    // ------------------------------------------------------------ scoreboards
    logic [31:0] rd_q  [$];
    logic [63:0] dac_q [$];
    bit          bl_q  [$];
    bit          wv_q  [$];

    bit drv = 1'b0;
    bit due_cyc = 1'b0;
    bit due_nxt = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_en = 0; m_uf = 0; m_of = 0;
        m_cnt = 0; m_thr = 0; m_stage = 0; m_out = 0;
        rd_q.delete(); dac_q.delete(); bl_q.delete(); wv_q.delete();
    endtask

    // One bus/codec cycle: drive inputs after a falling edge, predict the
    // effect of the coming rising edge, then wait for the next falling edge.
    task automatic cycle(bit wr, bit rd, logic [7:0] addr, logic [31:0] wd, bit nxt);
        bit          en_pre, flush, popped, uflow;
        int          sz;
        logic [63:0] pair;
        logic [31:0] rv;
        lb_wr_en = wr; lb_rd_en = rd; lb_addr = addr; lb_wr_data = wd;
        dac_pcm_nxt = nxt; drv = 1'b1;

        en_pre = m_en;
        sz     = mq.size();
        bl_q.push_back(m_en && (sz < m_thr));
        wv_q.push_back(wr);

        if (rd) begin
            case (addr)
                8'h00:   rv = {31'd0, m_en};
                8'h01:   rv = {12'd0, m_of, m_uf, sz == DEPTH, sz == 0, 16'(sz)};
                8'h02:   rv = m_stage;
                8'h03:   rv = 32'd0;
                8'h04:   rv = 32'(m_thr);
                8'h05:   rv = 32'(m_cnt);
                default: rv = 32'hdeadbabe;
            endcase
            rd_q.push_back(rv);
        end

        flush = wr && (addr == 8'h00) && wd[1];
        if (wr) begin
            case (addr)
                8'h00: m_en = wd[0];
                8'h01: begin
                    if (wd[18]) m_uf = 0;
                    if (wd[19]) m_of = 0;
                end
                8'h02: m_stage = wd;
                8'h04: m_thr = int'(wd[6:0]);
                8'h05: m_cnt = 0;
                default: ;
            endcase
        end

        popped = 0; uflow = 0; pair = '0;
        if (nxt && en_pre && !flush) begin
            if (mq.size() > 0) begin
                pair = mq.pop_front();
                popped = 1;
            end else begin
                uflow = 1;
                m_uf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
        end

        if (flush) mq.delete();
        else if (wr && addr == 8'h03) begin
            if (mq.size() < DEPTH) mq.push_back({m_stage, wd});
            else m_of = 1;
        end

        if (!m_en || flush) m_out = '0;
        else if (popped) m_out = pair;
`ifndef DAC_PCM_FIFO_UFLOW_REPEAT_EN
        else if (uflow) m_out = '0;
`endif
        if (nxt) dac_q.push_back(m_out);

        @(negedge clk);
    endtask

    task automatic bus_wr(logic [7:0] a, logic [31:0] d); cycle(1, 0, a, d, 0); endtask
    task automatic bus_rd(logic [7:0] a);                cycle(0, 1, a, 0, 0); endtask
    task automatic pop();                                cycle(0, 0, 0, 0, 1); endtask
    task automatic idle();                               cycle(0, 0, 0, 0, 0); endtask
    task automatic push_pair(logic [31:0] l, logic [31:0] r);
        bus_wr(8'h02, l);
        bus_wr(8'h03, r);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(posedge clk) begin
        due_cyc = drv && rst_n;
        due_nxt = drv && rst_n && dac_pcm_nxt;
    end

    always @(negedge clk) begin
        if (due_cyc) begin
            if (bl_q.size() == 0 || wv_q.size() == 0) missing("cycle_sb");
            else begin
                check("buff_low", 64'(buff_low), 64'(bl_q.pop_front()));
                check("lb_wr_valid", 64'(lb_wr_valid), 64'(wv_q.pop_front()));
            end
        end
        if (due_nxt) begin
            if (dac_q.size() == 0) missing("dac_sb");
            else check("dac_pair", {dac_lpcm_data, dac_rpcm_data}, dac_q.pop_front());
        end
        if (lb_rd_valid) begin
            if (rd_q.size() == 0) missing("rd_sb");
            else check("lb_rd_data", 64'(lb_rd_data), 64'(rd_q.pop_front()));
        end
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] wd;
        logic [7:0]  a;
        int          k;
        model_reset();

        #1;
        check("rst_dac_l", 64'(dac_lpcm_data), 64'd0);
        check("rst_dac_r", 64'(dac_rpcm_data), 64'd0);
        check("rst_buff_low", 64'(buff_low), 64'd0);
        check("rst_rd_data", 64'(lb_rd_data), 64'd0);
        check("rst_valids", {62'd0, lb_wr_valid, lb_rd_valid}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic push / pop and status after it.
        bus_rd(8'h01);
        bus_wr(8'h00, 32'h1);
        push_pair(32'h11111111, 32'h22222222);
        pop();
        bus_rd(8'h01);

        // Fill to full, overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) push_pair($urandom, $urandom);
        push_pair(32'hbad0bad0, 32'hbad1bad1);
        bus_rd(8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            pop();
            if ($urandom_range(0, 3) == 0) idle();
        end
        bus_rd(8'h01);
        bus_wr(8'h01, 32'h000c_0000);

        // Three underflows, counter and sticky clear.
        pop(); pop(); pop();
        bus_rd(8'h05);
        bus_rd(8'h01);
        bus_wr(8'h05, 32'h0);
        bus_rd(8'h05);
        bus_wr(8'h01, 32'h0004_0000);
        bus_rd(8'h01);

        // Full + push + pop, then empty + push + pop.
        for (int i = 0; i < DEPTH; i++) push_pair($urandom, $urandom);
        bus_wr(8'h02, 32'hcafe0001);
        cycle(1, 0, 8'h03, 32'hcafe0002, 1);
        bus_rd(8'h01);
        bus_wr(8'h00, 32'h3);
        bus_wr(8'h02, 32'h5a5a5a5a);
        cycle(1, 0, 8'h03, 32'ha5a5a5a5, 1);
        bus_rd(8'h05);
        bus_rd(8'h01);
        pop();

        // Low-water threshold crossing and flush.
        bus_wr(8'h04, 32'd8);
        bus_wr(8'h00, 32'h3);
        for (int i = 0; i < 7; i++) push_pair($urandom, $urandom);
        idle(); idle();
        push_pair($urandom, $urandom);
        idle(); idle();
        pop();
        idle(); idle();
        for (int i = 0; i < 13; i++) push_pair($urandom, $urandom);
        bus_rd(8'h01);
        bus_wr(8'h00, 32'h3);
        idle(); idle();
        pop();
        bus_rd(8'h01);
        bus_rd(8'h04);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 15);
            case (k)
                0:          a = 8'h00;
                1:          a = 8'h01;
                2, 3, 4:    a = 8'h02;
                11:         a = 8'h04;
                12:         a = 8'h05;
                13:         a = 8'h06;
                14:         a = 8'h20;
                default:    a = 8'h03;
            endcase
            case (a)
                8'h00:   wd = {30'd0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) != 0)};
                8'h04:   wd = 32'($urandom_range(0, 70));
                default: wd = $urandom;
            endcase
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 25, a, wd,
                  $urandom_range(0, 99) < 40);
        end

        // Reset mid-stream at occupancy 10.
        bus_wr(8'h00, 32'h3);
        bus_wr(8'h00, 32'h1);
        for (int i = 0; i < 11; i++) push_pair($urandom, $urandom);
        pop();
        bus_rd(8'h02);
        idle();
        drv = 1'b0;
        lb_wr_en = 0; lb_rd_en = 0; dac_pcm_nxt = 0; lb_addr = 0; lb_wr_data = 0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dac_l", 64'(dac_lpcm_data), 64'd0);
        check("mid_rst_dac_r", 64'(dac_rpcm_data), 64'd0);
        check("mid_rst_rd_data", 64'(lb_rd_data), 64'd0);
        check("mid_rst_buff_low", 64'(buff_low), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rd(8'h20);
        pop();
        bus_rd(8'h01);
        bus_rd(8'h04);
        bus_rd(8'h02);
        idle(); idle();

        check("rd_sb_drained", 64'(rd_q.size()), 64'd0);
        check("dac_sb_drained", 64'(dac_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
